counter_enable_gen: RTL and testbench
=====================================

# counter_enable_gen

Programmable enable-strobe generator that sits directly upstream of the 4-bit synchronous up counter and drives its active-high `enable` input. It divides the clock by a latched prescale value and issues single-cycle enable strobes, either continuously or as a fixed-length burst. A small run-control FSM handles start and stop.

## Interface

- `PRESCALE_W`, 8, width of prescale field; strobe period = `prescale`+1 cycles
- `BURST_W`, 4, width of burst length and strobe counter; matches the 4-bit counter

- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  level sampled each edge; begins a run from IDLE
- `stop`  in  1  level sampled each edge; aborts a run
- `mode`  in  1  0 = continuous, 1 = burst; latched at start
- `prescale`  in  PRESCALE_W  strobe spacing minus one; latched at start
- `burst_len`  in  BURST_W  strobes per burst; 0 means 2^BURST_W; latched at start
- `enable`  out  1  one-cycle strobe to the counter's enable input
- `busy`  out  1  high while FSM is in RUN
- `done`  out  1  one-cycle pulse at burst completion or stop-abort
- `tick_count`  out  BURST_W  strobes issued in current/last run

## Operation

- States: IDLE, RUN. All outputs registered.
- Reset: state=IDLE; `enable`, `busy`, `done` = 0; `tick_count` = 0; prescale counter and latches = 0.
- IDLE:
  - `start`=1 and `stop`=0 -> RUN.
  - Latch `mode`, `prescale`, `burst_len`. Prescale counter=0, `tick_count`=0, `busy`<=1.
  - `start`=1 and `stop`=1 -> stay IDLE. No `done`, no state change.
- RUN, evaluated each edge in priority order:
  1. `stop`=1 -> IDLE. `enable`<=0, `busy`<=0, `done`<=1. `tick_count` holds.
  2. Prescale counter == latched prescale -> `enable`<=1, prescale counter<=0, `tick_count`<=`tick_count`+1 (wraps modulo 2^BURST_W).
     - Burst mode and `tick_count` == latched `burst_len`-1 (mod 2^BURST_W): also `done`<=1, `busy`<=0, -> IDLE.
  3. Otherwise prescale counter +1, `enable`<=0.
- `start` while in RUN is ignored. New `prescale`, `burst_len` or `mode` values take effect only at the next start.
- Continuous mode never self-terminates. It runs until `stop`; `tick_count` wraps 15->0 for BURST_W=4.
- After a run ends, `tick_count` holds its final value until the next accepted start.
- `done` and `enable` are each exactly one cycle wide. `done` is never asserted from IDLE.

## Timing

- Start accepted at edge E0.
- First `enable` is high in the cycle after edge E(p+1), where p = latched prescale. Subsequent strobes follow every p+1 cycles.
- p=0 gives `enable` high every cycle starting after E1.
- Burst: the last strobe, the `done` pulse and the fall of `busy` occur in the same cycle. A new `start` can be accepted at the next edge.
- Stop sampled at edge Es: `enable` is 0 and `done` is 1 in the cycle after Es. A strobe due at Es is suppressed.
- `reset` asserted mid-run forces outputs to reset values without waiting for a clock edge. After release, the block sits in IDLE until `start`.

## Test plan

- Reset mid-run: assert `reset` asynchronously between edges while `enable` is high. Outputs go to 0 before the next edge. After release, no strobes until `start`.
- Burst, p=2, `burst_len`=3, `start` at E0:
  - `enable` high after E3, E6, E9.
  - `done`=1 and `busy`=0 in the cycle after E9.
  - `tick_count`=3 and holds; counter downstream reads 3.
- Burst, p=0, `burst_len`=0: 16 consecutive `enable` cycles, then `done`. `tick_count` ends at 0 (wrapped). Downstream counter wraps back to 0.
- Continuous, p=1: 20 strobes on alternate cycles; `tick_count` wraps 15->0. Then assert `stop` on an edge where a strobe is due: that strobe is suppressed, `done`=1 for one cycle, `busy`=0, `tick_count`=4.
- `start`=`stop`=1 in IDLE: no state change, `done` stays 0. In RUN, change `prescale` 2->5 and pulse `start`: spacing stays 3 cycles, no restart.
- Back-to-back: `start` held high through burst end (p=0, `burst_len`=2). A new run begins the edge after `done`; `tick_count` clears to 0 then counts to 2 again.

Source files
------------

// File: rtl/counter_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module   : counter_enable_gen
//  Purpose  : Prescaled enable-strobe generator with continuous/burst modes
//             and a start/stop run-control FSM, feeding a counter's enable.
//  Revision : 1.0  initial release
// ============================================================================
module counter_enable_gen #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BURST_W-1:0]    burst_len,
    output logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic [BURST_W-1:0]    tick_count
);

    localparam logic [PRESCALE_W-1:0] c_PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0]    c_TICK_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_mode;
    logic [PRESCALE_W-1:0]   r_prescale;
    logic [BURST_W-1:0]      r_burst_len;
    logic [PRESCALE_W-1:0]   r_pcnt;
    logic                    r_enable;
    logic                    r_busy;
    logic                    r_done;
    logic [BURST_W-1:0]      r_tick_count;

    logic                    w_strobe_due;
    logic                    w_last_strobe;
    logic [BURST_W-1:0]      w_last_tick;

    // A burst length of 0 wraps to all-ones here, giving 2^BURST_W strobes.
    assign w_last_tick   = r_burst_len - c_TICK_ONE;
    assign w_strobe_due  = (r_pcnt == r_prescale);
    assign w_last_strobe = r_mode && (r_tick_count == w_last_tick);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_prescale   <= '0;
            r_burst_len  <= '0;
            r_pcnt       <= '0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_enable <= 1'b0;
                    r_done   <= 1'b0;
                    if (start && !stop) begin
                        r_mode       <= mode;
                        r_prescale   <= prescale;
                        r_burst_len  <= burst_len;
                        r_pcnt       <= '0;
                        r_tick_count <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        // Abort wins over a strobe due on the same edge.
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (w_strobe_due) begin
                        r_enable     <= 1'b1;
                        r_pcnt       <= '0;
                        r_tick_count <= r_tick_count + c_TICK_ONE;
                        if (w_last_strobe) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_pcnt   <= r_pcnt + c_PCNT_ONE;
                        r_enable <= 1'b0;
                        r_done   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign enable     = r_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign tick_count = r_tick_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_enable_gen.sv
`default_nettype none
// Testbench for counter_enable_gen: expected per-cycle outputs are queued from
// closed-form timing rules and compared one cycle at a time after each edge.
module tb_counter_enable_gen;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] prescale;
    logic [3:0] burst_len;
    logic       enable;
    logic       busy;
    logic       done;
    logic [3:0] tick_count;

    typedef struct packed {
        logic       en;
        logic       dn;
        logic       bz;
        logic [3:0] tk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    counter_enable_gen #(.PRESCALE_W(8), .BURST_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .prescale   (prescale),
        .burst_len  (burst_len),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .tick_count (tick_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Queue expectations for edges E0..Ekmax of a run accepted at E0.
    function automatic void push_run(input int p, input int len, input bit burst, input int kmax);
        int   l;
        int   last;
        int   s;
        exp_t e;
        l    = (len == 0) ? 16 : len;
        last = l * (p + 1);
        for (int k = 0; k <= kmax; k++) begin
            s = k / (p + 1);
            if (burst) begin
                e.en = (k >= 1) && (k % (p + 1) == 0) && (k <= last);
                e.dn = (k == last);
                e.bz = (k < last);
                e.tk = 4'((s > l) ? l : s);
            end else begin
                e.en = (k >= 1) && (k % (p + 1) == 0);
                e.dn = 1'b0;
                e.bz = 1'b1;
                e.tk = 4'(s);
            end
            q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({enable, done, busy, tick_count} !== 7'b0) begin
            n_fails++;
            $display("FAIL reset_state: got en=%b done=%b busy=%b tick=%0d, expected all 0",
                     enable, done, busy, tick_count);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_burst(input int p, input int len, input string name);
        exp_t e;
        int   i = 0;
        mode = 1'b1; prescale = 8'(p); burst_len = 4'(len); start = 1'b1;
        push_run(p, len, 1'b1, ((len == 0) ? 16 : len) * (p + 1) + 3);
        while (q.size() > 0) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({enable, done, busy, tick_count} !== e) begin
                n_fails++;
                $display("FAIL %s cycle %0d: got en=%b done=%b busy=%b tick=%0d, expected en=%b done=%b busy=%b tick=%0d",
                         name, i, enable, done, busy, tick_count, e.en, e.dn, e.bz, e.tk);
            end
            if (i == 0) start = 1'b0;
            i++;
        end
    endtask

    task automatic test_continuous();
        exp_t e;
        int   i = 0;
        mode = 1'b0; prescale = 8'd1; burst_len = 4'd3; start = 1'b1;
        push_run(1, 0, 1'b0, 41);
        q.push_back('{en: 1'b0, dn: 1'b1, bz: 1'b0, tk: 4'd4});
        q.push_back('{en: 1'b0, dn: 1'b0, bz: 1'b0, tk: 4'd4});
        while (q.size() > 0) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({enable, done, busy, tick_count} !== e) begin
                n_fails++;
                $display("FAIL continuous cycle %0d: got en=%b done=%b busy=%b tick=%0d, expected en=%b done=%b busy=%b tick=%0d",
                         i, enable, done, busy, tick_count, e.en, e.dn, e.bz, e.tk);
            end
            if (i == 0)  start = 1'b0;
            if (i == 41) stop  = 1'b1;
            if (i == 42) stop  = 1'b0;
            i++;
        end
    endtask

    task automatic test_start_stop();
        exp_t e;
        int   i = 0;
        mode = 1'b0; prescale = 8'd2; start = 1'b1; stop = 1'b1;
        repeat (3) q.push_back('{en: 1'b0, dn: 1'b0, bz: 1'b0, tk: 4'd4});
        push_run(2, 0, 1'b0, 10);
        q.push_back('{en: 1'b0, dn: 1'b1, bz: 1'b0, tk: 4'd3});
        q.push_back('{en: 1'b0, dn: 1'b0, bz: 1'b0, tk: 4'd3});
        while (q.size() > 0) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({enable, done, busy, tick_count} !== e) begin
                n_fails++;
                $display("FAIL start_stop cycle %0d: got en=%b done=%b busy=%b tick=%0d, expected en=%b done=%b busy=%b tick=%0d",
                         i, enable, done, busy, tick_count, e.en, e.dn, e.bz, e.tk);
            end
            case (i)
                2:  stop = 1'b0;
                3:  start = 1'b0;
                4:  begin prescale = 8'd5; start = 1'b1; end
                5:  start = 1'b0;
                13: stop = 1'b1;
                14: stop = 1'b0;
                default: ;
            endcase
            i++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   i = 0;
        mode = 1'b1; prescale = 8'd0; burst_len = 4'd2; start = 1'b1;
        push_run(0, 2, 1'b1, 2);
        push_run(0, 2, 1'b1, 3);
        while (q.size() > 0) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({enable, done, busy, tick_count} !== e) begin
                n_fails++;
                $display("FAIL back_to_back cycle %0d: got en=%b done=%b busy=%b tick=%0d, expected en=%b done=%b busy=%b tick=%0d",
                         i, enable, done, busy, tick_count, e.en, e.dn, e.bz, e.tk);
            end
            if (i == 5) start = 1'b0;
            i++;
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   i = 0;
        mode = 1'b0; prescale = 8'd0; start = 1'b1;
        push_run(0, 0, 1'b0, 3);
        while (q.size() > 0) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({enable, done, busy, tick_count} !== e) begin
                n_fails++;
                $display("FAIL reset_run cycle %0d: got en=%b done=%b busy=%b tick=%0d, expected en=%b done=%b busy=%b tick=%0d",
                         i, enable, done, busy, tick_count, e.en, e.dn, e.bz, e.tk);
            end
            if (i == 0) start = 1'b0;
            i++;
        end
        // Enable is high here; reset must clear outputs before any further edge.
        reset = 1'b1;
        #1;
        n_checks++;
        if ({enable, done, busy, tick_count} !== 7'b0) begin
            n_fails++;
            $display("FAIL reset_async: got en=%b done=%b busy=%b tick=%0d, expected all 0",
                     enable, done, busy, tick_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) q.push_back('{en: 1'b0, dn: 1'b0, bz: 1'b0, tk: 4'd0});
        i = 0;
        while (q.size() > 0) begin
            @(posedge clock);
            #1;
            e = q.pop_front();
            n_checks++;
            if ({enable, done, busy, tick_count} !== e) begin
                n_fails++;
                $display("FAIL reset_idle cycle %0d: got en=%b done=%b busy=%b tick=%0d, expected en=%b done=%b busy=%b tick=%0d",
                         i, enable, done, busy, tick_count, e.en, e.dn, e.bz, e.tk);
            end
            i++;
        end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; mode = 1'b0;
        prescale = 8'd0; burst_len = 4'd0; reset = 1'b0;
        test_reset();
        test_burst(2, 3, "burst_p2_l3");
        test_burst(0, 0, "burst_p0_l0");
        test_continuous();
        test_start_stop();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
